wb_rr_arbiter: RTL



---
 rtl/wb_rr_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: shares one Wishbone slave port between N masters.
// Round-robin grant, one transaction in flight, watchdog ends stuck cycles
// with a one-cycle error pulse to the owning master.
module wb_rr_arbiter #(
  parameter int N    = 2,
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int TO_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*AW-1:0]   m_addr,
  input  logic [N*DW-1:0]   m_wdata,
  input  logic [N-1:0]      m_we,
  input  logic [N-1:0]      m_cyc,
  output logic [DW-1:0]     m_rdata,
  output logic [N-1:0]      m_ack,
  output logic [N-1:0]      m_err,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  output logic              s_we,
  output logic              s_cyc,
  input  logic [DW-1:0]     s_rdata,
  input  logic              s_ack,
  output logic [1:0]        gnt_idx,
  output logic              busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [TO_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0] CNT_PRE = TO_W'((1 << TO_W) - 2);

  state_t          state;
  // gnt only changes when a new grant is made, so between transactions it
  // holds the last granted master and doubles as the round-robin pointer.
  logic [1:0]      gnt;
  logic [TO_W-1:0] cnt;
  logic [N-1:0]    err;

  logic [N-1:0]    gnt_oh;
  logic [1:0]      pick;
  logic            pick_vld;
  logic            cyc_g;
  logic            timed;

  // One-hot form of the grant, used for every per-master mux and response.
  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N; i++) gnt_oh[i] = (int'(gnt) == i);
  end

  // Round-robin pick: scan gnt+1 .. gnt+N; walking the offsets downwards
  // lets the nearest requester overwrite the farther ones.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = gnt;
    pick_vld = 1'b0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(gnt) + i) % N;
      if (m_cyc[idx]) begin
        pick     = 2'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Slave-side mux of the granted master's request signals.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_we    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh[i]) begin
        s_addr  = m_addr[i*AW +: AW];
        s_wdata = m_wdata[i*DW +: DW];
        s_we    = m_we[i];
      end
    end
  end

  assign cyc_g   = |(m_cyc & gnt_oh);
  // The watchdog cycle itself: error is showing, slave cycle is withdrawn.
  assign timed   = (state == BUSY) && (cnt == CNT_MAX);
  // Reset also masks the slave cycle so an ack landing during reset is dropped.
  assign s_cyc   = (state == BUSY) && cyc_g && !timed && !rst;
  assign m_ack   = (s_cyc && s_ack) ? gnt_oh : '0;
  assign m_err   = err;
  assign m_rdata = s_rdata;
  assign busy    = (state == BUSY);
  assign gnt_idx = gnt;

  // Arbitration FSM with watchdog; err is armed one cycle ahead so the
  // error pulse is registered and lands exactly when the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 2'(N - 1);
      cnt   <= '0;
      err   <= '0;
    end else begin
      err <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_vld) begin
            gnt   <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Watchdog expiry, abort by the master, or a valid ack all end it.
          if (timed || !cyc_g || s_ack) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_PRE) err <= gnt_oh;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
